// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared state encoding, default vectors and PC step sizes for pc_ctrl
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;
  localparam logic [31:0] STEP_C        = 32'd2;
  localparam logic [31:0] STEP_W        = 32'd4;

endpackage

// File: rtl/instret_cnt.sv
// rtl/instret_cnt.sv - 32-bit retired-instruction counter, wraps at 2^32
module instret_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - next-PC selection FSM (BOOT/RUN/HALT/TRAP) with pending redirect
// Misaligned-target trap is built only with PC_CTRL_MISALIGN_TRAP_EN defined.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_is_compressed,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  input  logic        i_resume,
  output logic [31:0] o_pc_next,
  output logic        o_pc_wren,
  output logic [1:0]  o_state,
  output logic        o_misalign,
  output logic [31:0] o_instret
);

`ifdef PC_CTRL_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t      state, state_nxt;
  logic        pend_valid, pend_valid_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        cnt_en;
  logic        take;
  logic [31:0] target;

  // A fresh redirect always beats an older pending target.
  assign take   = i_redirect | pend_valid;
  assign target = i_redirect ? i_redirect_pc : pend_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_BOOT;
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    o_pc_next      = i_pc;
    o_pc_wren      = 1'b0;
    o_misalign     = 1'b0;
    cnt_en         = 1'b0;

    case (state)
      ST_BOOT: begin
        o_pc_wren = 1'b1;
        o_pc_next = RESET_VEC;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_stall) begin
          if (i_redirect) begin
            pend_valid_nxt = 1'b1;
            pend_pc_nxt    = i_redirect_pc;
          end
        end else if (i_halt) begin
          state_nxt = ST_HALT;
          if (i_redirect) begin
            pend_valid_nxt = 1'b1;
            pend_pc_nxt    = i_redirect_pc;
          end
        end else begin
          o_pc_wren      = 1'b1;
          cnt_en         = 1'b1;
          pend_valid_nxt = 1'b0;
          if (!take) begin
            o_pc_next = i_pc + (i_is_compressed ? STEP_C : STEP_W);
          end else if (TRAP_EN && target[0]) begin
            o_pc_next  = TRAP_VEC;
            o_misalign = 1'b1;
            state_nxt  = ST_TRAP;
          end else begin
            o_pc_next = target & ~32'h1;
          end
        end
      end
      ST_HALT: begin
        if (i_resume) state_nxt = ST_RUN;
      end
      ST_TRAP: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase

    if (i_rst) begin
      o_pc_wren  = 1'b1;
      o_pc_next  = RESET_VEC;
      o_misalign = 1'b0;
      cnt_en     = 1'b0;
    end
  end

  assign o_state = state;

  instret_cnt u_instret (
    .clk   (i_clk),
    .rst   (i_rst),
    .en    (cnt_en),
    .count (o_instret)
  );

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, boot address loaded after reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, misaligned-target trap handler address.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_pc  input  32  current PC, fed back from the PC register output.
REQ-006 i_stall  input  1  hold the PC this cycle.
REQ-007 i_is_compressed  input  1  instruction at i_pc is 16-bit.
REQ-008 i_redirect  input  1  taken branch or jump this cycle.
REQ-009 i_redirect_pc  input  32  branch or jump target.
REQ-010 i_halt  input  1  halt request (ebreak).
REQ-011 i_resume  input  1  leave HALT.
REQ-012 o_pc_next  output  32  next PC value to the PC register.
REQ-013 o_pc_wren  output  1  PC register write enable.
REQ-014 o_state  output  2  FSM state encoding.
REQ-015 o_misalign  output  1  one-cycle pulse when a misaligned-target trap is taken.
REQ-016 o_instret  output  32  retired-instruction counter.

Function
REQ-017 The FSM SHALL have four states: BOOT=0, RUN=1, HALT=2, TRAP=3.
REQ-018 BOOT SHALL drive o_pc_wren=1 and o_pc_next=RESET_VEC for one cycle, then move to RUN.
REQ-019 In RUN with i_stall=0, o_pc_wren SHALL be 1, and o_pc_next SHALL be selected in priority order:
  - redirect target;
  - pending target;
  - i_pc+2 if i_is_compressed, else i_pc+4.
REQ-020 PC arithmetic SHALL be 32-bit modulo, so 32'hFFFF_FFFC+4=32'h0000_0000 and 32'hFFFF_FFFE+2=32'h0000_0000.
REQ-021 In RUN with i_stall=1, o_pc_wren SHALL be 0, and a concurrent i_redirect SHALL latch i_redirect_pc into the pending register (pend_valid=1).
REQ-022 A newer redirect SHALL overwrite an existing pending target.
REQ-023 pend_valid SHALL clear on the first non-stalled RUN cycle that consumes the pending target or a fresh redirect.
REQ-024 In RUN with i_stall=0 and i_halt=1, o_pc_wren SHALL be 0 and the next state SHALL be HALT.
REQ-025 When i_halt and i_redirect are both asserted, halt SHALL win and the redirect target SHALL be latched as pending.
REQ-026 i_halt SHALL be ignored while i_stall=1.
REQ-027 In HALT, o_pc_wren SHALL be 0.
REQ-028 In HALT, i_resume=1 SHALL move the FSM to RUN with no PC write in that cycle, and pending state SHALL be preserved across HALT.
REQ-029 o_instret SHALL increment by 1 on each RUN cycle with o_pc_wren=1, wrap at 2^32, and never increment in BOOT, HALT or TRAP.
REQ-030 o_misalign SHALL be 0 in every cycle except as specified in REQ-035.

Reset
REQ-031 While i_rst=1 at a rising edge:
  - the next state SHALL be BOOT;
  - pend_valid and the pending target SHALL be 0;
  - o_instret SHALL be 0.
REQ-032 While i_rst=1, o_pc_wren=1, o_pc_next=RESET_VEC and o_misalign=0, so the PC register holds RESET_VEC from the first edge.
REQ-033 Reset asserted in any state (including HALT, TRAP, or stalled with a pending redirect) SHALL discard all in-flight state.

Configuration
REQ-034 The trap feature SHALL be compiled in only when macro PC_CTRL_MISALIGN_TRAP_EN is defined.
REQ-035 With PC_CTRL_MISALIGN_TRAP_EN defined, a selected redirect or pending target with bit0=1 in non-stalled RUN SHALL produce:
  - o_pc_next=TRAP_VEC, o_pc_wren=1 and o_misalign=1 in that cycle;
  - the TRAP state for one cycle with o_pc_wren=0;
  - then a return to RUN, with no o_instret increment in that cycle.
REQ-036 Without PC_CTRL_MISALIGN_TRAP_EN, bit0 of a selected target SHALL be forced to 0, the TRAP state SHALL be unreachable, and o_misalign SHALL be tied to 0.

Structure
REQ-037 A shared package pc_ctrl_pkg SHALL hold:
  - the state enum;
  - the default RESET_VEC and TRAP_VEC values;
  - the step constants (2 and 4).
REQ-038 The retired-instruction counter SHALL be a separate sub-module instret_cnt with enable, synchronous reset and a 32-bit output.
REQ-039 pc_ctrl SHALL integrate with the existing PC register by connecting o_pc_next and o_pc_wren to its next-PC and write-enable ports.
REQ-040 The PC register output SHALL be returned to pc_ctrl on i_pc.

Verification
REQ-041 The bench SHALL cover these directed scenarios:
  - Reset: hold i_rst=1 for 2 cycles, then release -> PC=0; BOOT for one cycle then RUN; o_instret=0.
  - Sequential: run 3 cycles from PC=0 with compressed flags 0,1,0 -> PC 4, 6, 10; o_instret=3.
  - Stalled redirect: at PC=8, i_stall=1 and i_redirect to 32'h40 for 2 cycles, then i_stall=0 -> PC holds 8, then becomes 32'h40; pending cleared.
  - Halt with redirect: i_halt and i_redirect to 32'h80 together at PC=0x10 -> HALT with PC held; after i_resume, the first RUN cycle loads 32'h80.
  - Wrap: PC=32'hFFFF_FFFC with a 4-byte step -> next PC=0; o_instret wraps from 32'hFFFF_FFFF to 0.
  - Misaligned target (macro defined): redirect to 32'h101 -> PC=32'h100 with a one-cycle o_misalign pulse and one TRAP cycle.
  - Misaligned target (macro undefined): redirect to 32'h101 -> PC=32'h100 with no o_misalign pulse.
